// File: rtl/equal_arbiter_pkg.sv
// Shared types and default sizing for the equality-comparator arbiter.
package equal_arbiter_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      sel = ID_W'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
        grant[sel]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/equal_arbiter.sv
// Round-robin front end sharing one bitwise-equality comparator among NUM_REQ
// requesters; returns the captured result tagged with the owner id.
module equal_arbiter
  import equal_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic [WIDTH-1:0]         cmp_z,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_z,
  output logic                     resp_all_eq,
  output logic [CNT_W-1:0]         done_count
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, id_q, grant_idx, ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               may_accept, accept, consume;
  logic [WIDTH-1:0]   sel_a, sel_b;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    may_accept = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        may_accept = 1'b1;
        if (grant_valid) state_nxt = EVAL;
      end
      EVAL: state_nxt = RESP;
      RESP: begin
        // Consuming a response reopens the port in the same cycle.
        if (resp_ready) begin
          consume    = 1'b1;
          may_accept = 1'b1;
          state_nxt  = grant_valid ? EVAL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = may_accept && grant_valid && !rst;
  assign req_ready  = (may_accept && !rst) ? grant : '0;
  assign resp_valid = (state == RESP);
  assign ptr_nxt    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      cmp_a       <= '0;
      cmp_b       <= '0;
      resp_z      <= '0;
      resp_id     <= '0;
      resp_all_eq <= 1'b0;
      done_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmp_a  <= sel_a;
        cmp_b  <= sel_b;
        id_q   <= grant_idx;
        rr_ptr <= ptr_nxt;
      end
      if (state == EVAL) begin
        resp_z      <= cmp_z;
        resp_all_eq <= &cmp_z;
        resp_id     <= id_q;
      end
      if (consume) done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_equal_arbiter.sv
// Scoreboard bench for equal_arbiter: directed vectors, queued expectations.
module tb_equal_arbiter;

  localparam int WIDTH   = 64;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;

  typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } op_t;
  typedef struct { logic [ID_W-1:0] id; logic [WIDTH-1:0] z; logic eq; } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         cmp_a, cmp_b, cmp_z;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_z;
  logic                     resp_all_eq;
  logic [CNT_W-1:0]         done_count;

  op_t  pend [NUM_REQ][$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [CNT_W-1:0]   exp_done = '0;
  int                 acc_q[$];
  int                 cyc = 0;
  bit                 prev_v = 1'b0;
  bit                 hold = 1'b0;
  logic [ID_W-1:0]    h_id = '0;
  logic [WIDTH-1:0]   h_z = '0;
  logic [NUM_REQ-1:0] fired = '0;

  always #5 clk = ~clk;

  // Shared comparator lives outside the arbiter.
  assign cmp_z = ~(cmp_a ^ cmp_b);

  equal_arbiter #(
    .WIDTH  (WIDTH),
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_z      (cmp_z),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_z     (resp_z),
    .resp_all_eq(resp_all_eq),
    .done_count (done_count)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    pend[k].push_back(o);
  endtask

  task automatic push_exp(input int id, input logic [WIDTH-1:0] z, input logic eq);
    exp_t e;
    e.id = ID_W'(id);
    e.z  = z;
    e.eq = eq;
    sb.push_back(e);
  endtask

  function automatic bit busy();
    bit b = (sb.size() != 0);
    for (int k = 0; k < NUM_REQ; k++) if (pend[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_timeout", WIDTH'(busy()), '0);
  endtask

  // Requester driver: present queued operands, retire them once accepted.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++)
        if (fired[k] && pend[k].size() != 0) void'(pend[k].pop_front());
      for (int k = 0; k < NUM_REQ; k++) begin
        if (pend[k].size() != 0) begin
          req_valid[k]             = 1'b1;
          req_a[k*WIDTH +: WIDTH]  = pend[k][0].a;
          req_b[k*WIDTH +: WIDTH]  = pend[k][0].b;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      #1;
      fired = req_valid & req_ready & {NUM_REQ{~rst}};
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        exp_done = '0;
        acc_q.delete();
        prev_v = 1'b0;
        hold   = 1'b0;
        continue;
      end
      chk("ready_onehot", WIDTH'($onehot0(req_ready)), 1);
      if (|(req_valid & req_ready)) acc_q.push_back(cyc);
      if (resp_valid && !prev_v) begin
        chk("latency_has_accept", WIDTH'(acc_q.size() != 0), 1);
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          chk("latency", WIDTH'(cyc - a), 2);
        end
      end
      if (hold) begin
        chk("hold_valid", WIDTH'(resp_valid), 1);
        chk("hold_id", WIDTH'(resp_id), WIDTH'(h_id));
        chk("hold_z", resp_z, h_z);
        if (!resp_ready) chk("hold_req_ready", WIDTH'(req_ready), 0);
      end
      if (resp_valid && resp_ready) begin
        chk("resp_expected", WIDTH'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_id", WIDTH'(resp_id), WIDTH'(e.id));
          chk("resp_z", resp_z, e.z);
          chk("resp_all_eq", WIDTH'(resp_all_eq), WIDTH'(e.eq));
        end
        chk("done_count_at_resp", WIDTH'(done_count), WIDTH'(exp_done));
        exp_done++;
      end
      hold   = resp_valid && !resp_ready;
      h_id   = resp_id;
      h_z    = resp_z;
      prev_v = resp_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst        = 1'b1;
    resp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_resp_valid", WIDTH'(resp_valid), 0);
    chk("rst_req_ready", WIDTH'(req_ready), 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_cmp_b", cmp_b, 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_id", WIDTH'(resp_id), 0);
    chk("rst_all_eq", WIDTH'(resp_all_eq), 0);
    chk("rst_done", WIDTH'(done_count), 0);

    // Single requester, mismatching bits.
    tick();
    resp_ready = 1'b1;
    push_op(0, 64'd5, 64'd1);
    push_exp(0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    wait_drain(20);
    chk("t1_done", WIDTH'(done_count), 1);

    // Requester 1: partial then full equality.
    push_op(1, '1, 64'd10);
    push_op(1, 64'd10, 64'd10);
    push_exp(1, 64'h0000_0000_0000_000A, 1'b0);
    push_exp(1, '1, 1'b1);
    wait_drain(30);
    chk("t2_done", WIDTH'(done_count), 3);

    // All four contending from rr_ptr = 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_op(0, 64'd0, 64'd0);
    push_op(0, 64'hF0, 64'h0F);
    push_op(1, 64'd0, 64'd1);
    push_op(1, 64'h1234, 64'h1234);
    push_op(2, 64'd0, 64'd2);
    push_op(3, 64'd0, 64'd3);
    push_exp(0, '1, 1'b1);
    push_exp(1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    push_exp(2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    push_exp(3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    push_exp(0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    push_exp(1, '1, 1'b1);
    wait_drain(60);
    chk("t3_done", WIDTH'(done_count), 6);

    // Back-pressure: response held 5 cycles while req2 waits.
    resp_ready = 1'b0;
    push_op(2, 64'd1, 64'd1);
    push_op(2, 64'd2, 64'd3);
    push_exp(2, '1, 1'b1);
    push_exp(2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 20);
    chk("t4_resp_seen", WIDTH'(resp_valid), 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_req_ready_on_rise", WIDTH'(req_ready), 4'b0100);
    chk("t4_valid_on_rise", WIDTH'(resp_valid), 1);
    @(negedge clk);
    #1;
    chk("t4_done_inc", WIDTH'(done_count), 7);
    wait_drain(30);
    chk("t4_done", WIDTH'(done_count), 8);

    // Reset during EVAL drops the transaction.
    tick();
    push_op(3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd10);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(req_valid[3] && req_ready[3]) && n < 20);
    chk("t5_accept_seen", WIDTH'(req_valid[3] && req_ready[3]), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_valid_after_rst", WIDTH'(resp_valid), 0);
    chk("t5_done_after_rst", WIDTH'(done_count), 0);
    repeat (3) tick();
    push_op(1, 64'd7, 64'd7);
    push_op(3, 64'hFF00, 64'h00FF);
    push_exp(1, '1, 1'b1);
    push_exp(3, 64'hFFFF_FFFF_FFFF_0000, 1'b0);
    wait_drain(30);
    chk("t5_done", WIDTH'(done_count), 2);

    // Fill the counter to its top value, then wrap.
    for (int i = 0; i < 300 && exp_done != '1; i++) begin
      push_op(0, 64'd0, 64'd0);
      push_exp(0, '1, 1'b1);
      wait_drain(20);
    end
    chk("wrap_pre", WIDTH'(done_count), 255);
    push_op(0, 64'd3, 64'd5);
    push_exp(0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    wait_drain(20);
    chk("wrap", WIDTH'(done_count), 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/equal_arbiter.md
Name: equal_arbiter

Overview:
- Controller that shares one bitwise-equality datapath (Z[i] = 1 iff A[i] == B[i]) among NUM_REQ requesters.
- Each requester offers a 64-bit operand pair over a valid/ready handshake.
- The block grants one requester at a time, round-robin. It drives the registered operands into the shared comparator and returns the captured result, tagged with the requester id, over a valid/ready response port.
- It sits between the requesting units and the single comparator instance in the top level.

Parameters:
- WIDTH, 64, operand and result width.
- NUM_REQ, 4, number of requesters (>= 2).
- ID_W, $clog2(NUM_REQ), width of the requester id.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_ready  output  NUM_REQ  per-requester ready; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  flattened A operands; requester k at [k*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened B operands, same packing.
- cmp_a  output  WIDTH  operand A to the shared comparator (registered).
- cmp_b  output  WIDTH  operand B to the shared comparator (registered).
- cmp_z  input  WIDTH  comparator result, combinational from cmp_a/cmp_b.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  index of the requester that owns the response.
- resp_z  output  WIDTH  captured cmp_z.
- resp_all_eq  output  1  AND-reduction of the captured cmp_z.
- done_count  output  CNT_W  completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - cmp_a, cmp_b, resp_z, resp_id, resp_all_eq, done_count all 0.
  - resp_valid = 0, req_ready = 0 in the cycle after reset.
- Winner selection: combinational. Search req_valid starting at rr_ptr, ascending, wrapping at NUM_REQ. The first set bit wins. No winner if req_valid == 0.
- Handshake: a request is accepted in a cycle where req_valid[k] and req_ready[k] are both high.
  - req_ready[k] is high only for the current winner, and only in states that may accept.
  - Requesters hold valid and operands stable until accepted.
- On accept of k:
  - cmp_a/cmp_b <= operands of k; id_q <= k.
  - rr_ptr <= (k+1) mod NUM_REQ.
  - state <= EVAL.
- State IDLE: may accept. With no request, stay in IDLE.
- State EVAL: req_ready all 0. Capture resp_z <= cmp_z, resp_all_eq <= &cmp_z, resp_id <= id_q. Then go to RESP.
- State RESP: resp_valid = 1.
  - resp_ready = 0: hold. resp_* stable, req_ready all 0.
  - resp_ready = 1: response consumed and done_count increments. In the same cycle the block may accept the winner; on accept go to EVAL, otherwise go to IDLE.
- Latency and throughput:
  - resp_valid rises in the second cycle after the accept cycle.
  - Maximum throughput is one transaction per 2 cycles.
- cmp_a/cmp_b hold their last values while idle.
- Reset asserted in any state takes priority. An in-flight transaction is dropped and no response is produced.
- done_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package equal_arbiter_pkg holds:
  - the state enum {IDLE, EVAL, RESP} as a 2-bit typedef;
  - the default WIDTH and NUM_REQ constants.
- Sub-module rr_arbiter (parameter NUM_REQ) is natural: inputs req, ptr; outputs one-hot grant and grant index. It is purely combinational.
- The comparator is not instantiated inside the block; it connects through the cmp_* ports.

Test Plan:
- Only req0, A=5, B=1, resp_ready=1 -> resp_z=0xFFFF_FFFF_FFFF_FFFB, resp_all_eq=0, resp_id=0, resp_valid 2 cycles after accept, done_count=1.
- req1, A=0xFFFF_FFFF_FFFF_FFFF, B=10 -> resp_z=0x0000_0000_0000_000A. Then A=10, B=10 -> resp_z all ones, resp_all_eq=1.
- All four requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,1; responses every 2 cycles; resp_id follows the same order.
- resp_ready low 5 cycles during RESP, req2 valid -> resp_valid/id/z stable and req_ready=0 throughout. On the cycle resp_ready rises, req_ready[2]=1, req2 is accepted, and done_count increments.
- rst pulsed while in EVAL (req3, A=-5, B=10) -> no response; next cycle resp_valid=0, done_count=0. Then, with req1 and req3 both valid, req1 wins because rr_ptr reset to 0.
- done_count preloaded by 65535 completions -> the next completion wraps it to 0.
